// File: rtl/register_writeback_pkg.sv
// Shared constants and types for the register writeback scoreboard.
// Unit indices, bus widths, bank encoding and the captured-result record.
package register_writeback_pkg;

   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 32;
   localparam int NUM_UNITS = 4;

   localparam int UNIT_MISC = 0;
   localparam int UNIT_ALU  = 1;
   localparam int UNIT_MEM  = 2;
   localparam int UNIT_FPU  = 3;

   typedef enum logic {
      BANK_INT   = 1'b0,
      BANK_FLOAT = 1'b1
   } bank_e;

   typedef struct packed {
      logic              valid;
      logic              flt;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_result_t;

   // Int r0 is hardwired to zero: never pending, never written.
   function automatic logic is_int_zero(input logic flt, input logic [ADDR_W-1:0] addr);
      return (bank_e'(flt) == BANK_INT) && (addr == '0);
   endfunction

endpackage

// File: rtl/register_writeback_if.sv
// Issue, result and write-port bundle of the register writeback block.
// master = decoder/execution units side, slave = register_writeback.
interface register_writeback_if;
   import register_writeback_pkg::*;

   logic              issue_valid;
   logic [ADDR_W-1:0] issue_addr;
   logic              issue_float;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic              rs_float;
   logic              rt_float;
   logic              issue_accept;
   logic              stall;
   logic              rs_pending;
   logic              rt_pending;

   logic              result_valid_misc, result_valid_alu, result_valid_mem, result_valid_fpu;
   logic [ADDR_W-1:0] result_addr_misc,  result_addr_alu,  result_addr_mem,  result_addr_fpu;
   logic [DATA_W-1:0] result_data_misc,  result_data_alu,  result_data_mem,  result_data_fpu;
   logic              result_float_misc, result_float_alu, result_float_mem, result_float_fpu;

   logic              write_enable_misc, write_enable_alu, write_enable_mem, write_enable_fpu;
   logic [ADDR_W-1:0] write_addr_misc,   write_addr_alu,   write_addr_mem,   write_addr_fpu;
   logic [DATA_W-1:0] write_data_misc,   write_data_alu,   write_data_mem,   write_data_fpu;
   logic              write_float_misc,  write_float_alu,  write_float_mem,  write_float_fpu;

   logic              result_unexpected;

   modport master (
      output issue_valid, issue_addr, issue_float, rs_addr, rt_addr, rs_float, rt_float,
      output result_valid_misc, result_valid_alu, result_valid_mem, result_valid_fpu,
      output result_addr_misc, result_addr_alu, result_addr_mem, result_addr_fpu,
      output result_data_misc, result_data_alu, result_data_mem, result_data_fpu,
      output result_float_misc, result_float_alu, result_float_mem, result_float_fpu,
      input  issue_accept, stall, rs_pending, rt_pending, result_unexpected,
      input  write_enable_misc, write_enable_alu, write_enable_mem, write_enable_fpu,
      input  write_addr_misc, write_addr_alu, write_addr_mem, write_addr_fpu,
      input  write_data_misc, write_data_alu, write_data_mem, write_data_fpu,
      input  write_float_misc, write_float_alu, write_float_mem, write_float_fpu
   );

   modport slave (
      input  issue_valid, issue_addr, issue_float, rs_addr, rt_addr, rs_float, rt_float,
      input  result_valid_misc, result_valid_alu, result_valid_mem, result_valid_fpu,
      input  result_addr_misc, result_addr_alu, result_addr_mem, result_addr_fpu,
      input  result_data_misc, result_data_alu, result_data_mem, result_data_fpu,
      input  result_float_misc, result_float_alu, result_float_mem, result_float_fpu,
      output issue_accept, stall, rs_pending, rt_pending, result_unexpected,
      output write_enable_misc, write_enable_alu, write_enable_mem, write_enable_fpu,
      output write_addr_misc, write_addr_alu, write_addr_mem, write_addr_fpu,
      output write_data_misc, write_data_alu, write_data_mem, write_data_fpu,
      output write_float_misc, write_float_alu, write_float_mem, write_float_fpu
   );

endinterface

// File: rtl/register_writeback_port.sv
// writeback_port: one execution unit's result capture register, giving a
// one-cycle registered write port towards register_manager.
module writeback_port
   import register_writeback_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  wb_result_t res_in,
   output wb_result_t wr_out
);

   // Fields hold their last captured value; only valid pulses per result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_out <= '0;
      end else begin
         wr_out.valid <= res_in.valid && !is_int_zero(res_in.flt, res_in.addr);
         if (res_in.valid) begin
            wr_out.flt  <= res_in.flt;
            wr_out.addr <= res_in.addr;
            wr_out.data <= res_in.data;
         end
      end
   end

endmodule

// File: rtl/register_writeback.sv
// register_writeback: pending-register scoreboard with RAW/WAW stall and four
// registered write ports. Optional macro WB_FORWARD_EN enables same-cycle bypass.
module register_writeback
   import register_writeback_pkg::*;
#(
   parameter int NUM_REGS = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   register_writeback_if.slave  bus
);

   wb_result_t [NUM_UNITS-1:0] res;
   wb_result_t [NUM_UNITS-1:0] wr;

   logic [NUM_REGS-1:0] pend_int, pend_flt;
   logic [NUM_REGS-1:0] hit_int, hit_flt;
   logic [NUM_REGS-1:0] set_int, set_flt;
   logic [NUM_REGS-1:0] eff_int, eff_flt;
   logic                rs_pend, rt_pend, dst_pend;
   logic                stall_now, accept_now, unexp_now, unexpected;

   function automatic logic lookup(input logic [NUM_REGS-1:0] bits_int,
                                   input logic [NUM_REGS-1:0] bits_flt,
                                   input logic flt, input logic [ADDR_W-1:0] addr);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
         if (addr == ADDR_W'(i)) hit = flt ? bits_flt[i] : bits_int[i];
      return hit && !is_int_zero(flt, addr);
   endfunction

   assign res[UNIT_MISC] = '{bus.result_valid_misc, bus.result_float_misc, bus.result_addr_misc, bus.result_data_misc};
   assign res[UNIT_ALU]  = '{bus.result_valid_alu,  bus.result_float_alu,  bus.result_addr_alu,  bus.result_data_alu};
   assign res[UNIT_MEM]  = '{bus.result_valid_mem,  bus.result_float_mem,  bus.result_addr_mem,  bus.result_data_mem};
   assign res[UNIT_FPU]  = '{bus.result_valid_fpu,  bus.result_float_fpu,  bus.result_addr_fpu,  bus.result_data_fpu};

   for (genvar u = 0; u < NUM_UNITS; u++) begin : g_port
      writeback_port u_port (.clk(clk), .reset(reset), .res_in(res[u]), .wr_out(wr[u]));
   end

   // Registers targeted by any result this cycle; they clear at the capturing edge.
   always_comb begin
      hit_int = '0;
      hit_flt = '0;
      for (int u = 0; u < NUM_UNITS; u++)
         for (int i = 0; i < NUM_REGS; i++)
            if (res[u].valid && res[u].addr == ADDR_W'(i)) begin
               if (res[u].flt) hit_flt[i] = 1'b1;
               else            hit_int[i] = 1'b1;
            end
   end

`ifdef WB_FORWARD_EN
   assign eff_int = pend_int & ~hit_int;
   assign eff_flt = pend_flt & ~hit_flt;
`else
   assign eff_int = pend_int;
   assign eff_flt = pend_flt;
`endif

   assign rs_pend    = lookup(eff_int, eff_flt, bus.rs_float, bus.rs_addr);
   assign rt_pend    = lookup(eff_int, eff_flt, bus.rt_float, bus.rt_addr);
   assign dst_pend   = lookup(eff_int, eff_flt, bus.issue_float, bus.issue_addr);
   assign stall_now  = bus.issue_valid && (rs_pend || rt_pend || dst_pend);
   assign accept_now = bus.issue_valid && !stall_now;

   always_comb begin
      set_int = '0;
      set_flt = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (accept_now && bus.issue_addr == ADDR_W'(i) && !is_int_zero(bus.issue_float, bus.issue_addr)) begin
            if (bus.issue_float) set_flt[i] = 1'b1;
            else                 set_int[i] = 1'b1;
         end
   end

   // A result is unexpected if its register was idle or another unit hit it too.
   always_comb begin
      unexp_now = 1'b0;
      for (int u = 0; u < NUM_UNITS; u++)
         if (res[u].valid && !is_int_zero(res[u].flt, res[u].addr)) begin
            if (!lookup(pend_int, pend_flt, res[u].flt, res[u].addr)) unexp_now = 1'b1;
            for (int v = 0; v < u; v++)
               if (res[v].valid && res[v].flt == res[u].flt && res[v].addr == res[u].addr)
                  unexp_now = 1'b1;
         end
   end

   // New issue wins over a same-cycle result so the register stays pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_int   <= '0;
         pend_flt   <= '0;
         unexpected <= 1'b0;
      end else begin
         pend_int <= (pend_int & ~hit_int) | set_int;
         pend_flt <= (pend_flt & ~hit_flt) | set_flt;
         if (unexp_now) unexpected <= 1'b1;
      end
   end

   assign bus.stall             = stall_now;
   assign bus.issue_accept      = accept_now;
   assign bus.rs_pending        = rs_pend;
   assign bus.rt_pending        = rt_pend;
   assign bus.result_unexpected = unexpected;

   assign bus.write_enable_misc = wr[UNIT_MISC].valid;
   assign bus.write_addr_misc   = wr[UNIT_MISC].addr;
   assign bus.write_data_misc   = wr[UNIT_MISC].data;
   assign bus.write_float_misc  = wr[UNIT_MISC].flt;
   assign bus.write_enable_alu  = wr[UNIT_ALU].valid;
   assign bus.write_addr_alu    = wr[UNIT_ALU].addr;
   assign bus.write_data_alu    = wr[UNIT_ALU].data;
   assign bus.write_float_alu   = wr[UNIT_ALU].flt;
   assign bus.write_enable_mem  = wr[UNIT_MEM].valid;
   assign bus.write_addr_mem    = wr[UNIT_MEM].addr;
   assign bus.write_data_mem    = wr[UNIT_MEM].data;
   assign bus.write_float_mem   = wr[UNIT_MEM].flt;
   assign bus.write_enable_fpu  = wr[UNIT_FPU].valid;
   assign bus.write_addr_fpu    = wr[UNIT_FPU].addr;
   assign bus.write_data_fpu    = wr[UNIT_FPU].data;
   assign bus.write_float_fpu   = wr[UNIT_FPU].flt;

endmodule

// File: doc/register_writeback.md
REGISTER_WRITEBACK -- requirements
Module: register_writeback

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, meaning registers per bank (int and float); address width is fixed at 5.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 issue_valid  input  1  decoder presents an instruction with a destination register.
REQ-005 issue_addr / issue_float  input  5 / 1  destination register and bank (1 = float).
REQ-006 rs_addr, rt_addr / rs_float, rt_float  input  5 / 1  source operands of the issuing instruction.
REQ-007 issue_accept  output  1  instruction accepted; its destination is now pending.
REQ-008 stall  output  1  issue_valid held off because of a RAW or WAW hazard.
REQ-009 rs_pending, rt_pending  output  1  the source operand awaits a result.
REQ-010 result_valid_X, result_addr_X[4:0], result_data_X[31:0], result_float_X  input  per unit X in {misc, alu, mem, fpu}  the unit has completed a result.
REQ-011 write_enable_X, write_addr_X[4:0], write_data_X[31:0], write_float_X  output  per unit X  write port driven to register_manager.
REQ-012 result_unexpected  output  1  sticky flag: a result arrived for a non-pending register.

Function
REQ-013 The block SHALL hold one pending bit per (bank, addr), 2*NUM_REGS bits in total.
REQ-014 stall SHALL be issue_valid AND (rs_pending OR rt_pending OR destination pending), evaluated combinationally.
REQ-015 issue_accept SHALL equal issue_valid AND NOT stall; on accept the destination pending bit SHALL be set at the next edge.
REQ-016 Int register 0 SHALL never become pending, SHALL never be reported pending, and its results SHALL be dropped with write_enable low.
REQ-017 Each result_valid_X SHALL be registered: write_*_X outputs SHALL equal the captured result exactly one cycle later, with write_enable_X high for exactly one cycle per result.
REQ-018 When result_valid_X is captured, the matching pending bit SHALL clear at the same edge.
REQ-019 If a result and an accepted issue target the same register in the same cycle, the pending bit SHALL end set.
REQ-020 If two units deliver results for the same (bank, addr) in the same cycle, both SHALL be written and result_unexpected SHALL be set.
REQ-021 A result for a register that is not pending SHALL still be written, and result_unexpected SHALL be set.
REQ-022 The four units SHALL be independent; results targeting different registers in the same cycle SHALL all be written with no added latency.

Reset
REQ-023 On reset, all pending bits, all write_enable_X and result_unexpected SHALL be cleared to 0; write_addr_X, write_data_X and write_float_X SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard in-flight captured results; no write_enable pulse SHALL follow the reset.

Configuration
REQ-025 Macro WB_FORWARD_EN: when defined, rs_pending/rt_pending/destination-pending SHALL exclude any register whose result_valid_X is present in the current cycle (same-cycle bypass, matching register_manager forwarding).
REQ-026 When WB_FORWARD_EN is undefined, pending SHALL come from the registered bits only, which costs one extra stall cycle.

Structure
REQ-027 A shared package SHALL hold the unit index constants (MISC=0, ALU=1, MEM=2, FPU=3), the address and data widths, and the bank encoding.
REQ-028 One sub-module, writeback_port, SHALL implement one unit's capture register, instantiated four times.

Verification
REQ-029 Issue alu int r4 -> issue_accept=1; then issue with rs=r4 -> stall=1 and rs_pending=1; result_alu r4=8 -> the next cycle write_enable_alu=1, addr 4, data 8; the stall SHALL drop the same cycle (forward) or one cycle later (no forward).
REQ-030 Issue fpu float r4 and alu int r4; results of 30 (fpu) and 92 (alu) in the same cycle -> both ports written, both pending bits cleared, result_unexpected=0.
REQ-031 Issue with destination int r0, then result misc r0=5 -> issue_accept=1 with no pending bit set; write_enable_misc=0.
REQ-032 result_mem float r8=3 with nothing pending -> write_enable_mem=1 and result_unexpected=1, held until reset.
REQ-033 Pending int r5, then in one cycle result_alu r5 and a new issue to r5 -> r5 still pending and the write issued.
REQ-034 Pending r4 with result_valid_mem captured, then reset asserted before the next edge -> write_enable_mem stays 0 and all pending bits are 0.
